// File: rtl/channel_mailbox.sv
// Channel-addressed message store: senders append {channel, data} in age order,
// and a single listener pulls the oldest message on its requested channel.
module channel_mailbox #(
  parameter int DEPTH  = 16,
  parameter int CHAN_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [CHAN_W-1:0]       channel_id,
  input  logic [DATA_W-1:0]       message_data,
  input  logic                    send_valid,
  output logic                    send_ready,
  input  logic [CHAN_W-1:0]       listen_channel_id,
  input  logic                    listen_valid,
  output logic                    listen_ready,
  input  logic                    listen_cancel,
  output logic [CHAN_W-1:0]       recv_channel_id,
  output logic [DATA_W-1:0]       recv_message,
  output logic                    recv_valid,
  input  logic                    recv_ready,
  output logic [$clog2(DEPTH):0]  occupancy,
  output logic [1:0]              state_debug
);

  localparam int OCC_W = $clog2(DEPTH) + 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEARCH  = 2'd1,
    WAIT    = 2'd2,
    DELIVER = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_armed;
  logic                w_armed_nxt;
  logic [OCC_W-1:0]    r_occ;
  logic [CHAN_W-1:0]   r_target;
  logic [CHAN_W-1:0]   r_chan [DEPTH];
  logic [DATA_W-1:0]   r_data [DEPTH];
  logic [CHAN_W-1:0]   r_recv_ch;
  logic [DATA_W-1:0]   r_recv_msg;

  logic                w_send;
  logic                w_send_match;
  logic                w_hit;
  logic [IDX_W-1:0]    w_hit_idx;
  logic                w_remove;
  logic [OCC_W-1:0]    w_wr_pos;
  logic [CHAN_W-1:0]   w_up_chan [DEPTH];
  logic [DATA_W-1:0]   w_up_data [DEPTH];

  assign send_ready      = (r_occ != OCC_W'(DEPTH));
  assign listen_ready    = (r_state == IDLE);
  assign recv_valid      = (r_state == DELIVER);
  assign recv_channel_id = r_recv_ch;
  assign recv_message    = r_recv_msg;
  assign occupancy       = r_occ;
  assign state_debug     = r_state;

  assign w_send       = send_valid && send_ready;
  assign w_send_match = w_send && (channel_id == r_target);
  assign w_wr_pos     = w_remove ? (r_occ - OCC_W'(1)) : r_occ;

  // Oldest matching slot wins: scan from the young end so the last write is the lowest index.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if ((OCC_W'(i) < r_occ) && (r_chan[i] == r_target)) begin
        w_hit     = 1'b1;
        w_hit_idx = IDX_W'(i);
      end
    end
  end

  // The first SEARCH cycle only arms the compare, fixing listen-to-valid at two edges.
  always_comb begin
    w_next      = r_state;
    w_armed_nxt = r_armed;
    w_remove    = 1'b0;
    case (r_state)
      IDLE: begin
        if (listen_valid) begin
          w_next      = SEARCH;
          w_armed_nxt = 1'b0;
        end
      end
      SEARCH: begin
        if (listen_cancel) begin
          w_next = IDLE;
        end else if (!r_armed) begin
          w_armed_nxt = 1'b1;
        end else if (w_hit) begin
          w_next   = DELIVER;
          w_remove = 1'b1;
        end else if (!w_send_match) begin
          w_next = WAIT;
        end
      end
      WAIT: begin
        if (listen_cancel) begin
          w_next = IDLE;
        end else if (w_send_match) begin
          w_next      = SEARCH;
          w_armed_nxt = 1'b0;
        end
      end
      DELIVER: begin
        if (recv_ready) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_armed    <= 1'b0;
      r_occ      <= '0;
      r_recv_ch  <= '0;
      r_recv_msg <= '0;
    end else begin
      r_state <= w_next;
      r_armed <= w_armed_nxt;
      if (w_send && !w_remove) begin
        r_occ <= r_occ + OCC_W'(1);
      end else if (!w_send && w_remove) begin
        r_occ <= r_occ - OCC_W'(1);
      end
      if (w_remove) begin
        r_recv_ch  <= r_chan[w_hit_idx];
        r_recv_msg <= r_data[w_hit_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (listen_valid && listen_ready) begin
      r_target <= listen_channel_id;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_up
    if (g < DEPTH - 1) begin : g_mid
      assign w_up_chan[g] = r_chan[g+1];
      assign w_up_data[g] = r_data[g+1];
    end else begin : g_last
      assign w_up_chan[g] = '0;
      assign w_up_data[g] = '0;
    end
  end

  // Removal compacts younger slots down; a same-cycle send lands in the freed top slot.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_send && (w_wr_pos == OCC_W'(i))) begin
        r_chan[i] <= channel_id;
        r_data[i] <= message_data;
      end else if (w_remove && (IDX_W'(i) >= w_hit_idx)) begin
        r_chan[i] <= w_up_chan[i];
        r_data[i] <= w_up_data[i];
      end
    end
  end

endmodule

// File: tb/tb_channel_mailbox.sv
// Directed scenarios plus a randomized run scored against a queue model of the mailbox.
module tb_channel_mailbox;

  logic        clk;
  logic        reset;
  logic [7:0]  channel_id;
  logic [31:0] message_data;
  logic        send_valid;
  logic        send_ready;
  logic [7:0]  listen_channel_id;
  logic        listen_valid;
  logic        listen_ready;
  logic        listen_cancel;
  logic [7:0]  recv_channel_id;
  logic [31:0] recv_message;
  logic        recv_valid;
  logic        recv_ready;
  logic [4:0]  occupancy;
  logic [1:0]  state_debug;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [7:0]  ch;
    logic [31:0] d;
  } msg_t;

  msg_t mq[$];

  channel_mailbox #(.DEPTH(16), .CHAN_W(8), .DATA_W(32)) dut (
    .clk               (clk),
    .reset             (reset),
    .channel_id        (channel_id),
    .message_data      (message_data),
    .send_valid        (send_valid),
    .send_ready        (send_ready),
    .listen_channel_id (listen_channel_id),
    .listen_valid      (listen_valid),
    .listen_ready      (listen_ready),
    .listen_cancel     (listen_cancel),
    .recv_channel_id   (recv_channel_id),
    .recv_message      (recv_message),
    .recv_valid        (recv_valid),
    .recv_ready        (recv_ready),
    .occupancy         (occupancy),
    .state_debug       (state_debug)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    tick();
    tick();
    chk({tag, "_state"}, state_debug, 0);
    chk({tag, "_occ"}, occupancy, 0);
    chk({tag, "_rvld"}, recv_valid, 0);
    chk({tag, "_rch"}, recv_channel_id, 0);
    chk({tag, "_rmsg"}, recv_message, 0);
    chk({tag, "_srdy"}, send_ready, 1);
    chk({tag, "_lrdy"}, listen_ready, 1);
    reset = 1'b0;
  endtask

  task automatic send_msg(input logic [7:0] ch, input logic [31:0] d);
    int k;
    k = 0;
    channel_id   = ch;
    message_data = d;
    send_valid   = 1'b1;
    while (!send_ready && k < 40) begin
      tick();
      k++;
    end
    if (!send_ready) chk("send_tmo", send_ready, 1);
    tick();
    send_valid = 1'b0;
  endtask

  task automatic do_listen(input logic [7:0] ch);
    listen_channel_id = ch;
    listen_valid      = 1'b1;
    tick();
    listen_valid      = 1'b0;
  endtask

  task automatic wait_recv(input string tag);
    int k;
    k = 0;
    while (!recv_valid && k < 40) begin
      tick();
      k++;
    end
    chk({tag, "_tmo"}, recv_valid, 1);
  endtask

  task automatic deliver(input string tag, input logic [7:0] ch, input logic [31:0] d);
    do_listen(ch);
    wait_recv(tag);
    chk({tag, "_ch"}, recv_channel_id, ch);
    chk({tag, "_msg"}, recv_message, d);
    recv_ready = 1'b1;
    tick();
    recv_ready = 1'b0;
    chk({tag, "_end"}, recv_valid, 0);
  endtask

  initial begin
    msg_t        pend;
    msg_t        cur;
    bit          pend_v;
    bit          in_dlv;
    logic [7:0]  tgt;
    int          k;

    reset = 1'b1;
    channel_id = '0; message_data = '0; send_valid = 1'b0;
    listen_channel_id = '0; listen_valid = 1'b0; listen_cancel = 1'b0;
    recv_ready = 1'b0;
    pend = '0; cur = '0; pend_v = 1'b0; in_dlv = 1'b0; tgt = '0;

    // Single message, exact two-edge latency
    do_reset("rst0");
    send_msg(8'd5, 32'hA);
    chk("l31_occ1", occupancy, 1);
    listen_channel_id = 8'd5;
    listen_valid = 1'b1;
    tick();
    listen_valid = 1'b0;
    chk("l31_search", state_debug, 1);
    chk("l31_rv_t0", recv_valid, 0);
    tick();
    chk("l31_rv_t1", recv_valid, 0);
    tick();
    chk("l31_rv_t2", recv_valid, 1);
    chk("l31_ch", recv_channel_id, 5);
    chk("l31_msg", recv_message, 32'hA);
    chk("l31_occ0", occupancy, 0);
    recv_ready = 1'b1;
    tick();
    recv_ready = 1'b0;
    chk("l31_rv_end", recv_valid, 0);
    chk("l31_idle", state_debug, 0);

    // Oldest match first, non-matching message left behind
    send_msg(8'd3, 32'h1);
    send_msg(8'd7, 32'h2);
    send_msg(8'd3, 32'h3);
    deliver("l32_a", 8'd3, 32'h1);
    deliver("l32_b", 8'd3, 32'h3);
    chk("l32_occ", occupancy, 1);
    deliver("l32_c", 8'd7, 32'h2);

    // Full-width channel compare, including channel 0 later
    send_msg(8'h81, 32'h1);
    send_msg(8'h01, 32'h2);
    deliver("exact_a", 8'h01, 32'h2);
    deliver("exact_b", 8'h81, 32'h1);

    // Listen before the message arrives, stalled receiver
    do_listen(8'd9);
    tick();
    tick();
    tick();
    chk("l33_wait", state_debug, 2);
    send_msg(8'd9, 32'hBEEF);
    wait_recv("l33");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("l33_hold_v", recv_valid, 1);
      chk("l33_hold_ch", recv_channel_id, 9);
      chk("l33_hold_msg", recv_message, 32'hBEEF);
    end
    recv_ready = 1'b1;
    tick();
    recv_ready = 1'b0;
    chk("l33_rv_end", recv_valid, 0);
    chk("l33_idle", state_debug, 0);

    // Fill, backpressure, drain one, held send accepted
    do_reset("rst1");
    for (int i = 0; i < 16; i++) send_msg(8'(i), 32'h100 + 32'(i));
    chk("l34_full_occ", occupancy, 16);
    chk("l34_full_srdy", send_ready, 0);
    channel_id = 8'h55;
    message_data = 32'hCAFE;
    send_valid = 1'b1;
    tick();
    tick();
    tick();
    chk("l34_held_occ", occupancy, 16);
    do_listen(8'd3);
    wait_recv("l34");
    chk("l34_msg", recv_message, 32'h103);
    chk("l34_occ15", occupancy, 15);
    chk("l34_srdy", send_ready, 1);
    recv_ready = 1'b1;
    tick();
    recv_ready = 1'b0;
    send_valid = 1'b0;
    chk("l34_occ16", occupancy, 16);
    deliver("l34_held", 8'h55, 32'hCAFE);
    deliver("l34_c4", 8'd4, 32'h104);
    deliver("l34_c0", 8'd0, 32'h100);
    chk("l34_occ13", occupancy, 13);

    // Send landing on the removal edge
    do_reset("rst2");
    send_msg(8'd1, 32'h11);
    send_msg(8'd2, 32'h22);
    do_listen(8'd1);
    tick();
    channel_id = 8'd6;
    message_data = 32'h66;
    send_valid = 1'b1;
    tick();
    send_valid = 1'b0;
    chk("same_rv", recv_valid, 1);
    chk("same_msg", recv_message, 32'h11);
    chk("same_occ", occupancy, 2);
    recv_ready = 1'b1;
    tick();
    recv_ready = 1'b0;
    deliver("same_b", 8'd2, 32'h22);
    deliver("same_c", 8'd6, 32'h66);
    chk("same_occ0", occupancy, 0);

    // Cancel from WAIT
    do_listen(8'd2);
    tick();
    tick();
    chk("l35_wait", state_debug, 2);
    listen_cancel = 1'b1;
    tick();
    listen_cancel = 1'b0;
    chk("l35_idle", state_debug, 0);
    chk("l35_lrdy", listen_ready, 1);
    chk("l35_rv", recv_valid, 0);
    tick();
    tick();
    chk("l35_rv_late", recv_valid, 0);

    // Reset in the middle of a delivery
    for (int i = 1; i <= 5; i++) send_msg(8'(i), 32'(i));
    do_listen(8'd1);
    wait_recv("l36");
    chk("l36_occ4", occupancy, 4);
    reset = 1'b1;
    tick();
    chk("l36_rv", recv_valid, 0);
    chk("l36_occ", occupancy, 0);
    chk("l36_state", state_debug, 0);
    chk("l36_rch", recv_channel_id, 0);
    chk("l36_rmsg", recv_message, 0);
    reset = 1'b0;
    tick();
    chk("l36_srdy", send_ready, 1);
    chk("l36_lrdy", listen_ready, 1);

    // Randomized traffic against the queue model
    do_reset("rst3");
    mq.delete();
    for (int c = 0; c < 1500; c++) begin
      if (pend_v) begin
        mq.push_back(pend);
        pend_v = 1'b0;
      end
      if (recv_valid && !in_dlv) begin
        k = -1;
        for (int j = 0; j < mq.size(); j++) begin
          if (k < 0 && mq[j].ch == tgt) k = j;
        end
        chk("rnd_hit", (k >= 0), 1);
        if (k >= 0) begin
          cur = mq[k];
          mq.delete(k);
        end
        in_dlv = 1'b1;
      end
      if (in_dlv) begin
        chk("rnd_vld", recv_valid, 1);
        chk("rnd_ch", recv_channel_id, cur.ch);
        chk("rnd_msg", recv_message, cur.d);
      end
      chk("rnd_occ", occupancy, mq.size());
      chk("rnd_srdy", send_ready, (mq.size() != 16));

      send_valid   = 1'($urandom_range(0, 1));
      channel_id   = 8'($urandom_range(0, 3));
      message_data = $urandom;
      if (send_valid && send_ready) begin
        pend   = {channel_id, message_data};
        pend_v = 1'b1;
      end
      if (listen_ready && $urandom_range(0, 2) == 0) begin
        listen_valid      = 1'b1;
        listen_channel_id = 8'($urandom_range(0, 3));
        tgt               = listen_channel_id;
      end else begin
        listen_valid = 1'b0;
      end
      listen_cancel = (state_debug == 2'd2) && ($urandom_range(0, 7) == 0);
      recv_ready    = 1'($urandom_range(0, 1));
      if (in_dlv && recv_ready) in_dlv = 1'b0;
      tick();
    end
    send_valid = 1'b0;
    listen_valid = 1'b0;
    listen_cancel = 1'b0;
    recv_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/channel_mailbox.md
CHANNEL_MAILBOX -- requirements
Module: channel_mailbox

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, meaning the number of message slots in the store.
REQ-002 The block SHALL have parameter CHAN_W, default 8, meaning the channel identifier width.
REQ-003 The block SHALL have parameter DATA_W, default 32, meaning the message payload width.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have ports channel_id (input, CHAN_W), message_data (input, DATA_W), send_valid (input, 1) and send_ready (output, 1): the message ingress from FPU send ports.
REQ-007 The block SHALL have ports listen_channel_id (input, CHAN_W), listen_valid (input, 1) and listen_ready (output, 1): a receive request from a receiving FPU.
REQ-008 The block SHALL have port listen_cancel, input, 1 bit: abandons a pending receive request.
REQ-009 The block SHALL have ports recv_channel_id (output, CHAN_W), recv_message (output, DATA_W), recv_valid (output, 1) and recv_ready (input, 1): message delivery to the receiving FPU.
REQ-010 The block SHALL have port occupancy, output, $clog2(DEPTH)+1 bits: the number of stored messages.
REQ-011 The block SHALL have port state_debug, output, 2 bits: the FSM state (IDLE=0, SEARCH=1, WAIT=2, DELIVER=3).

Function
REQ-012 The store SHALL be an age-ordered array: slot 0 is oldest, slots 0..occupancy-1 are valid, and each slot holds {channel, data}.
REQ-013 send_ready SHALL equal (occupancy != DEPTH), purely from registered state; a send is accepted when send_valid and send_ready are both high, and is appended at the youngest position.
REQ-014 A full store SHALL exert backpressure only and SHALL never drop or overwrite a message.
REQ-015 listen_ready SHALL be high only in IDLE; an accepted listen SHALL latch listen_channel_id as the target channel and move the FSM to SEARCH.
REQ-016 In SEARCH, a hit SHALL select the lowest-index slot whose channel equals the target, using the stored array only.
REQ-017 On a SEARCH hit, the block SHALL latch that slot's channel and data into recv_channel_id and recv_message, remove the slot by shifting all younger slots down one, and move to DELIVER.
REQ-018 On a SEARCH miss, the FSM SHALL stay in SEARCH if a send accepted in the same cycle matches the target, and SHALL otherwise move to WAIT.
REQ-019 WAIT SHALL move to SEARCH on the cycle after an accepted send matching the target channel.
REQ-020 Latency SHALL be as follows: a listen accepted at edge t with a match already stored gives recv_valid=1 from edge t+2.
REQ-021 In DELIVER, recv_valid SHALL be 1 and recv_channel_id and recv_message SHALL hold stable until recv_ready is 1; the FSM then moves to IDLE and recv_valid is 0 on the next cycle.
REQ-022 listen_cancel SHALL move the FSM to IDLE when in WAIT or SEARCH and SHALL be ignored in IDLE and DELIVER.
REQ-023 If a send is accepted in the same cycle as a removal, the compaction and the append SHALL both take effect.
REQ-024 For REQ-023, the new entry SHALL be written at index occupancy-1, and occupancy SHALL be unchanged.
REQ-025 Occupancy SHALL increment on append only, decrement on removal only, and never exceed DEPTH or go below 0.
REQ-026 Channel comparison SHALL be exact over all CHAN_W bits; channel value 0 is valid.

Reset
REQ-027 While reset is high at a clock edge, the FSM SHALL go to IDLE and occupancy to 0.
REQ-028 While reset is high at a clock edge, recv_valid, recv_channel_id, recv_message and state_debug SHALL be 0.
REQ-029 Reset SHALL leave send_ready=1 and listen_ready=1 after the edge, with slot contents don't-care.
REQ-030 Reset SHALL take priority over all inputs, including a reset asserted mid-DELIVER or mid-append.

Verification
REQ-031 Send ch5/0x0000000A, then listen ch5 -> recv_valid at listen edge +2 with recv_channel_id=5 and recv_message=0xA; occupancy goes 1->0.
REQ-032 Send ch3/0x1, ch7/0x2, ch3/0x3, then listen ch3 twice -> deliveries are 0x1 then 0x3; occupancy=1 with ch7/0x2 remaining.
REQ-033 Listen ch9 on an empty store, send ch9/0xBEEF 4 cycles later, hold recv_ready=0 for 3 cycles -> recv_valid stays 1 with stable data until the accept, then IDLE.
REQ-034 Issue 16 sends -> send_ready=0 and occupancy=16; a 17th send is held; listen and deliver one -> send_ready=1 and the held send is accepted.
REQ-035 Listen ch2, reach WAIT, pulse listen_cancel -> IDLE next cycle, listen_ready=1, and no recv_valid.
REQ-036 Assert reset during DELIVER with occupancy 4 -> next cycle recv_valid=0, occupancy=0 and state_debug=0.
